// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - request sequencer and 2-entry result buffer in front of alu_8bit
//
// Purpose:
//   Accepts ALU requests on a valid/ready input, registers operands and opcode
//   onto the alu_8bit inputs for one EXEC cycle, then captures the ALU result
//   (tagged with its opcode) into a 2-entry FIFO drained by a valid/ready output.
//
// Optional feature macro: ALU_SEQ_ACC_EN
//   Defined   : accumulator holds the last captured result; in_use_acc=1 at
//               acceptance substitutes it for operand A.
//   Undefined : no accumulator, in_use_acc ignored, acc tied to 0.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         request handshake
//   in_a, in_b, in_op         request operands and opaque opcode
//   in_use_acc                use accumulator as operand A (feature build only)
//   alu_a, alu_b, alu_op      registered drive to alu_8bit
//   alu_result                combinational result from alu_8bit
//   out_valid/out_ready       result handshake
//   out_result, out_op        buffer head result and its opcode
//   acc                       last captured result (0 when feature disabled)

module alu_op_sequencer #(
  parameter int W   = 8,
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic [OPW-1:0] in_op,
  input  logic           in_use_acc,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [W-1:0]   alu_result,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_result,
  output logic [OPW-1:0] out_op,
  output logic [W-1:0]   acc
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_alu_a;
  logic [W-1:0]   r_alu_b;
  logic [OPW-1:0] r_alu_op;

  logic [W-1:0]   r_buf_res [0:1];
  logic [OPW-1:0] r_buf_op  [0:1];
  logic [1:0]     r_count;
  logic           r_wptr;
  logic           r_rptr;

  logic           w_in_ready;
  logic           w_accept;
  logic           w_push;
  logic           w_pop;
  logic [W-1:0]   w_next_a;

  // Ready depends only on registered state; count==2 is flagged by bit 1.
  assign w_in_ready = (r_state == S_IDLE) && !r_count[1];
  assign w_accept   = in_valid && w_in_ready;
  assign w_push     = (r_state == S_EXEC);
  assign w_pop      = (r_count != 2'd0) && out_ready;

`ifdef ALU_SEQ_ACC_EN
  logic [W-1:0] r_acc;

  assign w_next_a = in_use_acc ? r_acc : in_a;
  assign acc      = r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_push) begin
      r_acc <= alu_result;
    end
  end
`else
  logic w_unused_use_acc;

  assign w_unused_use_acc = in_use_acc;
  assign w_next_a         = in_a;
  assign acc              = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= '0;
      r_count  <= 2'd0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_alu_a  <= w_next_a;
            r_alu_b  <= in_b;
            r_alu_op <= in_op;
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          // The ALU has had a full cycle to settle on the registered operands.
          r_buf_res[r_wptr] <= alu_result;
          r_buf_op[r_wptr]  <= r_alu_op;
          r_wptr            <= ~r_wptr;
          r_state           <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end

      // Push never meets a full buffer: acceptance already required count < 2.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign in_ready   = w_in_ready;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign out_valid  = (r_count != 2'd0);
  assign out_result = r_buf_res[r_rptr];
  assign out_op     = r_buf_op[r_rptr];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed self-checking bench for alu_op_sequencer

module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [2:0] in_op;
  logic       in_use_acc;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_result;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic [2:0] out_op;
  logic [7:0] acc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.W(8), .OPW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .in_use_acc (in_use_acc),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_op     (out_op),
    .acc        (acc)
  );

  // Stand-in for alu_8bit.
  always_comb begin
    alu_result = 8'h00;
    case (alu_op)
      3'd0: alu_result = alu_a + alu_b;
      3'd1: alu_result = alu_a - alu_b;
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = alu_a ^ alu_b;
      3'd5: alu_result = ~alu_a;
      3'd6: alu_result = alu_a << 1;
      3'd7: alu_result = alu_a >> 1;
      default: alu_result = 8'h00;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [7:0] exp_0f03 [0:7];
  logic [7:0] exp_aa55 [0:7];

  initial begin
    exp_0f03[0] = 8'h12; exp_0f03[1] = 8'h0C; exp_0f03[2] = 8'h03; exp_0f03[3] = 8'h0F;
    exp_0f03[4] = 8'h0C; exp_0f03[5] = 8'hF0; exp_0f03[6] = 8'h1E; exp_0f03[7] = 8'h07;
    exp_aa55[0] = 8'hFF; exp_aa55[1] = 8'h55; exp_aa55[2] = 8'h00; exp_aa55[3] = 8'hFF;
    exp_aa55[4] = 8'hFF; exp_aa55[5] = 8'h55; exp_aa55[6] = 8'h54; exp_aa55[7] = 8'h55;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    in_use_acc = 1'b0; out_ready = 1'b0;

    // Reset held two cycles.
    @(negedge clk);
    cyc();
    cyc();
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_acc", acc, 0);

    // Opcode sweep, back-to-back, two operand pairs.
    out_ready = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 8; k++) begin
        check("sweep_in_ready", in_ready, 1);
        in_valid = 1'b1;
        in_a  = (pass == 0) ? 8'h0F : 8'hAA;
        in_b  = (pass == 0) ? 8'h03 : 8'h55;
        in_op = k[2:0];
        cyc();
        in_valid = 1'b0;
        check("sweep_exec_no_valid", out_valid, 0);
        check("sweep_exec_in_ready", in_ready, 0);
        check("sweep_alu_op", alu_op, k);
        cyc();
        check("sweep_out_valid", out_valid, 1);
        check("sweep_out_result", out_result, (pass == 0) ? exp_0f03[k] : exp_aa55[k]);
        check("sweep_out_op", out_op, k);
      end
    end
    cyc();
    check("sweep_drained", out_valid, 0);

    // Backpressure: two buffered, third stalls.
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'h01; in_b = 8'h02; in_op = 3'd0;
    cyc();
    in_valid = 1'b0;
    cyc();
    in_valid = 1'b1; in_a = 8'h04; in_b = 8'h05; in_op = 3'd0;
    cyc();
    in_valid = 1'b0;
    cyc();
    check("bp_full_in_ready", in_ready, 0);
    check("bp_head_first", out_result, 8'h03);
    in_valid = 1'b1; in_a = 8'h10; in_b = 8'h20; in_op = 3'd0;
    cyc();
    check("bp_stall_in_ready", in_ready, 0);
    check("bp_stall_alu_a", alu_a, 8'h04);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("bp_after_pop_head", out_result, 8'h09);
    check("bp_after_pop_ready", in_ready, 1);
    cyc();
    in_valid = 1'b0;
    check("bp_third_alu_a", alu_a, 8'h10);
    cyc();
    check("bp_full_again", in_ready, 0);
    check("bp_head_second", out_result, 8'h09);
    out_ready = 1'b1;
    cyc();
    check("bp_head_third", out_result, 8'h30);
    check("bp_head_third_valid", out_valid, 1);
    cyc();
    check("bp_drained", out_valid, 0);

    // Simultaneous push and pop with count=1.
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'h01; in_b = 8'h01; in_op = 3'd0;
    cyc();
    in_valid = 1'b0;
    cyc();
    check("pp_first_head", out_result, 8'h02);
    in_valid = 1'b1; in_a = 8'h03; in_b = 8'h03; in_op = 3'd0;
    cyc();
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("pp_exec_valid", out_valid, 1);
    check("pp_exec_head", out_result, 8'h02);
    cyc();
    check("pp_after_valid", out_valid, 1);
    check("pp_after_head", out_result, 8'h06);
    check("pp_after_in_ready", in_ready, 1);
    cyc();
    check("pp_drained", out_valid, 0);

    // Reset asserted during EXEC.
    in_valid = 1'b1; in_a = 8'h0F; in_b = 8'h03; in_op = 3'd0;
    cyc();
    in_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rexec_acc", acc, 0);
    check("rexec_alu_a", alu_a, 0);
    for (int i = 0; i < 4; i++) begin
      check("rexec_no_result", out_valid, 0);
      cyc();
    end

    // Accumulator chain.
    in_valid = 1'b1; in_a = 8'h0F; in_b = 8'h03; in_op = 3'd0;
    cyc();
    in_valid = 1'b0;
    cyc();
    check("chain_first_result", out_result, 8'h12);
    in_valid = 1'b1; in_use_acc = 1'b1; in_a = 8'h01; in_b = 8'h03; in_op = 3'd0;
    cyc();
    in_valid = 1'b0; in_use_acc = 1'b0;
`ifdef ALU_SEQ_ACC_EN
    check("chain_alu_a", alu_a, 8'h12);
`else
    check("chain_alu_a", alu_a, 8'h01);
`endif
    cyc();
`ifdef ALU_SEQ_ACC_EN
    check("chain_result", out_result, 8'h15);
    check("chain_acc", acc, 8'h15);
`else
    check("chain_result", out_result, 8'h04);
    check("chain_acc", acc, 0);
`endif
    cyc();
    check("chain_drained", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Sequential front-end for the combinational `alu_8bit`. It accepts operation requests on a valid/ready input, drives the ALU operand and opcode ports from registers, and captures each ALU result into a 2-entry output buffer that drains through a valid/ready output. It is the requesting side of the ALU's a/b/op → result interface: the CPU datapath issues work through it instead of driving the ALU directly.

## Interface
Parameters:
- `W`, default 8: operand and result width; must match `alu_8bit`.
- `OPW`, default 3: opcode width.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  a request is present.
- `in_ready`  out  1  sequencer can accept a request this cycle.
- `in_a`  in  W  operand A.
- `in_b`  in  W  operand B.
- `in_op`  in  OPW  ALU opcode, passed through unmodified.
- `in_use_acc`  in  1  replace operand A with the accumulator (only with `ALU_SEQ_ACC_EN`).
- `alu_a`  out  W  registered operand A to `alu_8bit.a`.
- `alu_b`  out  W  registered operand B to `alu_8bit.b`.
- `alu_op`  out  OPW  registered opcode to `alu_8bit.op`.
- `alu_result`  in  W  from `alu_8bit.result`.
- `out_valid`  out  1  buffer head holds a result.
- `out_ready`  in  1  consumer accepts the head.
- `out_result`  out  W  buffer head result.
- `out_op`  out  OPW  opcode that produced the head result.
- `acc`  out  W  accumulator: last captured result.

## Operation
- FSM states: IDLE and EXEC.
- `in_ready` = (state == IDLE) && (buffer count < 2). It is combinational from registered state only and does not depend on `in_valid`.
- IDLE → EXEC on `in_valid && in_ready`. On that edge, `in_a`/`in_b`/`in_op` (or `acc` in place of A when chaining) are loaded into the `alu_*` registers.
- EXEC → IDLE unconditionally after one cycle. On that edge, {`alu_result`, `alu_op`} is pushed into the buffer, and `acc` ← `alu_result`.
- The `alu_*` registers hold their value between requests and change only on acceptance.
- Buffer: 2-entry FIFO with 2-bit count, 1-bit read and write pointers, and pointer wrap at 2.
  - Pop on `out_valid && out_ready`.
  - Push and pop in the same cycle leave count unchanged and move both pointers.
  - Push cannot overflow: acceptance requires count < 2, and no pop can raise the count before the push.
- `out_valid` = (count != 0). `out_result`/`out_op` come from the read-pointer entry and are stable while `out_valid && !out_ready`.
- Opcode is opaque. The sequencer performs no arithmetic and no width changes; `alu_result` is captured exactly as W bits.

## Timing
- Reset values: state IDLE, `alu_a`/`alu_b` = 0, `alu_op` = 0, count 0, both pointers 0, `out_valid` 0, `acc` 0. `in_ready` is 1 in the first cycle after reset.
- Request accepted at edge N → EXEC during cycle N+1 → result pushed at edge N+1 → `out_valid` high from cycle N+2. Latency is 2 cycles, accept to output.
- Maximum throughput is one request every 2 cycles (`in_ready` is low during EXEC).
- With `out_ready` low, at most 2 results are buffered. `in_ready` is held low until a pop.
- Reset asserted mid-EXEC: the pending result is discarded, nothing is pushed, and `acc` is cleared. Reset has priority over every other event.
- Pop of the last entry in the same cycle as an EXEC push: count stays 1 and `out_valid` stays high.

## Configuration
- `ALU_SEQ_ACC_EN` defined:
  - the accumulator register exists;
  - `in_use_acc = 1` at acceptance loads `acc` into `alu_a` instead of `in_a`;
  - `acc` reflects the last captured result.
- Not defined:
  - the accumulator logic is removed;
  - `in_use_acc` is ignored;
  - `alu_a` is always loaded from `in_a`;
  - the `acc` port is tied to 0.

## Test plan
- **Reset:** hold `rst` 2 cycles, then release. Required: `out_valid`=0, `in_ready`=1, `alu_a`/`alu_b`/`alu_op`=0, `acc`=0.
- **Opcode sweep:** `in_a`=0x0F, `in_b`=0x03, `in_op`=0..7 issued back-to-back, `out_ready`=1. Required: each `out_result` equals the `alu_8bit` output for that op, `out_op` matches, and each appears exactly 2 cycles after its acceptance. Repeat with 0xAA/0x55.
- **Backpressure:** `out_ready`=0 and issue 3 requests. Required: 2 accepted, third stalls with `in_ready`=0. Raise `out_ready` for one cycle: one pop, third accepted on the next IDLE cycle, results delivered in issue order.
- **Simultaneous push/pop:** with count=1 and `out_ready`=1, complete an EXEC on the same edge. Required: count stays 1, `out_valid` never drops, the new result is at the head next cycle.
- **Reset mid-EXEC:** accept a=0x0F b=0x03, then assert `rst` on the EXEC cycle. Required: no result is ever presented, and `acc`=0.
- **Accumulator chain (`ALU_SEQ_ACC_EN`):** issue a=0x0F b=0x03 op=k, then `in_use_acc`=1 b=0x03 op=k. Required: second `alu_a` equals the first result. Without the macro, second `alu_a` = `in_a` and `acc`=0.
